data_memory_line: RTL and testbench
===================================

// Module: data_memory_line
// PURPOSE
//   Line-granular backing data memory: the responder end of the dcache memory port.
//   Accepts 256-bit line read/write requests (enable/write/addr/data), waits a fixed
//   programmable latency, then returns a one-cycle ack (plus read data).
//   Sits below the dcache controller; one outstanding request at a time.
// PARAMETERS
//   LATENCY      10    cycles from request acceptance edge to the edge that raises ack_o; >=1
//   LINE_IDX_W   9     line-index width; array depth = 2**LINE_IDX_W lines of 256 bits
// PORTS
//   clk_i        in   1    clock, rising edge
//   rst_i        in   1    reset, asynchronous, active-low
//   enable_i     in   1    request valid; initiator holds it (with addr/write/data) until ack
//   write_i      in   1    1 = line write, 0 = line read; sampled at acceptance
//   addr_i       in   32   byte address; bits [4:0] ignored, line = addr_i[LINE_IDX_W+4:5]
//   data_i       in   256  write line; sampled at acceptance
//   ack_o        out  1    one-cycle completion pulse
//   data_o       out  256  read line; valid while ack_o=1 for reads, held until next read completes
// BEHAVIOUR
//   - Reset (async, rst_i=0): state IDLE, ack_o=0, data_o=0, counter=0, latched request cleared.
//     Array contents NOT reset (bench preloads). Reset mid-request aborts it; no write commits.
//   - States: IDLE, BUSY, ACK (encoding 2'b00/01/10).
//   - IDLE: at rising edge with enable_i=1 -> latch write_i, line index, data_i; counter<=0; -> BUSY.
//     enable_i=0 -> stay IDLE. write_i/addr_i/data_i in IDLE with enable_i=0 are don't-care.
//   - BUSY: counter increments each edge; at edge where counter==LATENCY-1 -> ACK, ack_o<=1;
//     on that same edge: write -> array[line]<=latched data; read -> data_o<=array[line].
//     Thus ack_o rises exactly LATENCY edges after the acceptance edge.
//   - ACK: ack_o high for exactly one cycle; next edge -> IDLE, ack_o<=0, unconditionally
//     (enable_i still high during ACK belongs to the completed request; never re-accepted).
//   - Back-to-back: initiator may keep enable_i high continuously (write-back then refill with
//     new addr/write); second request is accepted at the first edge in IDLE -> exactly one
//     bubble cycle between ack of request N and acceptance of request N+1.
//   - Inputs changing while BUSY are ignored (latched copy used). enable_i dropping while BUSY
//     does not abort; ack still issued.
//   - Read-after-write same line: write committed on ACK-entry edge, so any later read returns
//     new data. data_o unchanged by write requests.
//   - Counter width = $clog2(LATENCY)+1; no wrap possible since it resets each request.
//   - Address bits above LINE_IDX_W+4 ignored (aliasing, no error).
// STRUCTURE
//   - Shared package (mem_pkg): LINE_W=256, OFFSET_W=5, state typedef/encodings, ADDR_W=32;
//     dcache controller uses the same LINE_W/OFFSET_W constants.
//   - One sub-module: data_line_ram (synchronous single-port 2**LINE_IDX_W x 256 array,
//     write-enable, registered read); FSM + latency counter + request latch in this module.
// TESTING
//   1 Reset: rst_i=0 mid-BUSY of write to 0x0000_0040 -> ack_o=0 immediately, state IDLE,
//     line 2 unchanged after reset release.
//   2 Read latency: preload line 3 = {8{32'hDEAD_BEEF}}; enable=1,write=0,addr=0x60 accepted
//     edge E0 -> ack_o=1 only in cycle after edge E0+10, data_o=preload; ack width 1 cycle.
//   3 Write then read: write line 0x0000_0400 with 256'h1..F pattern, await ack, read same
//     addr -> data_o equals pattern; data_o unchanged during the write's ack.
//   4 Back-to-back continuous enable: write-back addr 0x0000_0800 then, enable held high,
//     refill read addr 0x0000_0020 -> exactly one idle cycle between ack1 and acceptance,
//     ack2 LATENCY edges later, two distinct ack pulses.
//   5 Input glitch: change addr_i/data_i/write_i and drop enable_i while BUSY -> ack still
//     issued, operation uses latched values; LATENCY=1 variant acks on edge after acceptance.
//   6 Aliasing: write addr 0x8000_0060, read addr 0x0000_0060 -> same data returned.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory-port constants and responder state encoding
package mem_pkg;
   localparam int LINE_W   = 256;
   localparam int OFFSET_W = 5;
   localparam int ADDR_W   = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_ACK  = 2'b10
   } mem_state_e;
endpackage

// File: rtl/data_line_ram.sv
// rtl/data_line_ram.sv - single-port line array, write-enable, registered read
module data_line_ram
   import mem_pkg::*;
#(
   parameter int unsigned IDX_W = 9
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  addr_i,
   input  logic [LINE_W-1:0] wdata_i,
   output logic [LINE_W-1:0] rdata_o
);
   localparam int unsigned DEPTH = 2 ** IDX_W;

   logic [LINE_W-1:0] mem_q [DEPTH];
   logic [LINE_W-1:0] rdata_q, rdata_d;

   // Array contents are deliberately left unreset; only the read register is cleared.
   always_ff @(posedge clk_i) begin
      if (en_i && we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (en_i && !we_i) begin
         rdata_d = mem_q[addr_i];
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/data_memory_line.sv
// rtl/data_memory_line.sv - fixed-latency line memory responder for the dcache port
module data_memory_line
   import mem_pkg::*;
#(
   parameter int unsigned LATENCY    = 10,
   parameter int unsigned LINE_IDX_W = 9
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic              write_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [LINE_W-1:0] data_i,
   output logic              ack_o,
   output logic [LINE_W-1:0] data_o
);
   localparam int unsigned CNT_W = $clog2(LATENCY) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

   mem_state_e              state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    req_we_q, req_we_d;
   logic [LINE_IDX_W-1:0]   req_idx_q, req_idx_d;
   logic [LINE_W-1:0]       req_data_q, req_data_d;
   logic                    ram_en;

   logic [LINE_IDX_W-1:0]   line_idx;
   logic                    unused_addr;

   assign line_idx    = addr_i[LINE_IDX_W+OFFSET_W-1:OFFSET_W];
   assign unused_addr = ^{addr_i[ADDR_W-1:LINE_IDX_W+OFFSET_W], addr_i[OFFSET_W-1:0]};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_we_d   = req_we_q;
      req_idx_d  = req_idx_q;
      req_data_d = req_data_q;
      ram_en     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (enable_i) begin
               req_we_d   = write_i;
               req_idx_d  = line_idx;
               req_data_d = data_i;
               cnt_d      = '0;
               state_d    = ST_BUSY;
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q + CNT_W'(1);
            // The array access lands on the same edge that raises ack.
            if (cnt_q == CNT_LAST) begin
               ram_en  = 1'b1;
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         req_we_q   <= 1'b0;
         req_idx_q  <= '0;
         req_data_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_we_q   <= req_we_d;
         req_idx_q  <= req_idx_d;
         req_data_q <= req_data_d;
      end
   end

   assign ack_o = (state_q == ST_ACK);

   data_line_ram #(
      .IDX_W (LINE_IDX_W)
   ) u_ram (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (ram_en),
      .we_i    (req_we_q),
      .addr_i  (req_idx_q),
      .wdata_i (req_data_q),
      .rdata_o (data_o)
   );
endmodule

// File: tb/tb_data_memory_line.sv
// tb/tb_data_memory_line.sv - directed self-checking bench for data_memory_line
module tb_data_memory_line;
   logic         clk_i = 1'b0;
   logic         rst_i = 1'b0;
   logic         enable, write;
   logic [31:0]  addr;
   logic [255:0] wdata;
   logic         ack;
   logic [255:0] rdata;
   logic         en1, we1;
   logic [31:0]  ad1;
   logic [255:0] wd1;
   logic         ack1;
   logic [255:0] rd1;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   data_memory_line #(.LATENCY(10), .LINE_IDX_W(9)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable), .write_i(write),
      .addr_i(addr), .data_i(wdata), .ack_o(ack), .data_o(rdata)
   );

   data_memory_line #(.LATENCY(1), .LINE_IDX_W(9)) dut1 (
      .clk_i(clk_i), .rst_i(rst_i), .enable_i(en1), .write_i(we1),
      .addr_i(ad1), .data_i(wd1), .ack_o(ack1), .data_o(rd1)
   );

   typedef struct {
      logic         we;
      logic [31:0]  addr;
      logic [255:0] data;
      logic [255:0] exp;
   } vec_t;

   localparam logic [255:0] DA = {8{32'h1111_0040}};
   localparam logic [255:0] DB = {8{32'hBAD0_BAD0}};
   localparam logic [255:0] DC = {4{64'hC0FF_EE00_8000_0060}};
   localparam logic [255:0] DD = {8{32'h0800_0800}};
   localparam logic [255:0] DE = {8{32'h2222_0020}};
   localparam logic [255:0] DF = {8{32'hF00D_0001}};
   localparam logic [255:0] DP = {4{64'h0123_4567_89AB_CDEF}};
   localparam logic [255:0] DX = {8{32'hDEAD_BEEF}};

   vec_t vecs[9];

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_ack(output int lat);
      lat = 0;
      while (!ack && lat < 50) begin
         tick();
         lat++;
      end
   endtask

   task automatic do_req(input string name, input logic we, input logic [31:0] a,
                         input logic [255:0] d, input logic [255:0] exp);
      int lat;
      enable = 1'b1; write = we; addr = a; wdata = d;
      tick();
      wait_ack(lat);
      check({name, " latency"}, 256'(lat), 256'(10));
      check({name, " data_o"}, rdata, exp);
      enable = 1'b0;
      tick();
      check({name, " ack width"}, 256'(ack), 256'(0));
   endtask

   initial begin
      int lat;
      enable = 0; write = 0; addr = '0; wdata = '0;
      en1 = 0; we1 = 0; ad1 = '0; wd1 = '0;

      vecs[0] = '{1'b1, 32'h0000_0040, DA, 256'h0};
      vecs[1] = '{1'b1, 32'h0000_0060, DX, 256'h0};
      vecs[2] = '{1'b0, 32'h0000_0060, '0, DX};
      vecs[3] = '{1'b1, 32'h0000_0400, DP, DX};
      vecs[4] = '{1'b0, 32'h0000_0400, '0, DP};
      vecs[5] = '{1'b1, 32'h0000_0020, DE, DP};
      vecs[6] = '{1'b1, 32'h8000_0060, DC, DP};
      vecs[7] = '{1'b0, 32'h0000_0060, '0, DC};
      vecs[8] = '{1'b0, 32'h0000_0040, '0, DA};

      tick(); tick();
      rst_i = 1'b1;
      tick();
      check("reset ack", 256'(ack), 256'(0));
      check("reset data_o", rdata, 256'h0);
      check("reset state", 256'(dut.state_q), 256'(2'b00));

      for (int i = 0; i < 9; i++) begin
         do_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].exp);
      end

      // back-to-back: write-back then refill with enable held high
      enable = 1'b1; write = 1'b1; addr = 32'h0000_0800; wdata = DD;
      tick();
      wait_ack(lat);
      check("b2b ack1 latency", 256'(lat), 256'(10));
      check("b2b ack1 data_o", rdata, DA);
      write = 1'b0; addr = 32'h0000_0020; wdata = '0;
      tick();
      check("b2b bubble ack", 256'(ack), 256'(0));
      check("b2b bubble state", 256'(dut.state_q), 256'(2'b00));
      tick();
      check("b2b accept state", 256'(dut.state_q), 256'(2'b01));
      wait_ack(lat);
      check("b2b ack2 latency", 256'(lat), 256'(10));
      check("b2b ack2 data_o", rdata, DE);
      enable = 1'b0;
      tick();
      check("b2b ack2 width", 256'(ack), 256'(0));
      do_req("b2b readback", 1'b0, 32'h0000_0800, '0, DD);

      // inputs change and enable drops while busy
      enable = 1'b1; write = 1'b0; addr = 32'h0000_0400; wdata = '0;
      tick();
      tick();
      enable = 1'b0; write = 1'b1; addr = 32'h0000_0060; wdata = DB;
      wait_ack(lat);
      check("glitch latency", 256'(lat + 1), 256'(10));
      check("glitch data_o", rdata, DP);
      tick();
      do_req("glitch no write", 1'b0, 32'h0000_0060, '0, DC);

      // asynchronous reset in the middle of a write to line 2
      enable = 1'b1; write = 1'b1; addr = 32'h0000_0040; wdata = DB;
      tick(); tick(); tick(); tick();
      #3 rst_i = 1'b0;
      #1;
      check("midreset ack", 256'(ack), 256'(0));
      check("midreset state", 256'(dut.state_q), 256'(2'b00));
      check("midreset data_o", rdata, 256'h0);
      enable = 1'b0;
      tick();
      rst_i = 1'b1;
      tick();
      do_req("midreset line2", 1'b0, 32'h0000_0040, '0, DA);

      // LATENCY=1 instance
      en1 = 1'b1; we1 = 1'b1; ad1 = 32'h0000_0040; wd1 = DF;
      tick();
      check("lat1 write busy", 256'(ack1), 256'(0));
      tick();
      check("lat1 write ack", 256'(ack1), 256'(1));
      check("lat1 write data_o", rd1, 256'h0);
      en1 = 1'b0;
      tick();
      check("lat1 write width", 256'(ack1), 256'(0));
      en1 = 1'b1; we1 = 1'b0; ad1 = 32'h0000_0040; wd1 = '0;
      tick();
      en1 = 1'b0; we1 = 1'b1; ad1 = 32'h0000_0060; wd1 = DB;
      tick();
      check("lat1 read ack", 256'(ack1), 256'(1));
      check("lat1 read data_o", rd1, DF);
      tick();
      check("lat1 read width", 256'(ack1), 256'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
